// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption core, one round per clock.
// A single shared round datapath (SubBytes -> ShiftRows -> MixColumns ->
// AddRoundKey) is reused for every middle round; the final round bypasses
// MixColumns. Round keys are fetched from an external key-expansion RAM via
// rk_idx / rk_data (combinational return in the same cycle).
// Optional feature: define AES_ENGINE_BLKCNT_EN to add the blk_cnt output,
// a wrapping count of accepted ciphertext handshakes.
module aes_round_engine #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
`ifdef AES_ENGINE_BLKCNT_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  // Reject illegal configurations at elaboration time.
  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_engine: NR must be 10, 12 or 14");
    end
    if ((1 << KIDX_W) <= NR) begin : g_bad_kidx
      $error("aes_round_engine: KIDX_W too narrow to index round NR");
    end
  endgenerate

  localparam logic [KIDX_W-1:0] NR_IDX     = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] LAST_ROUND = KIDX_W'(NR - 1);

  // AES forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              fsm_q, fsm_d;
  logic [KIDX_W-1:0]   cnt_q, cnt_d;
  logic [127:0]        st_q, st_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  // Shared round datapath, byte 0 of the AES state in bits [127:120].
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] round_out;
  logic [127:0] final_out;

  genvar gi;

  // SubBytes: one S-box lookup per state byte.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign sb[127-8*gi -: 8] = sbox(st_q[127-8*gi -: 8]);
    end
  endgenerate

  // ShiftRows: byte (row r, col c) takes the byte from (r, (c+r) mod 4).
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
    end
  endgenerate

  // MixColumns: each column multiplied by the circulant {02,03,01,01}.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[127-32*gi -: 8];
      assign a1 = sr[119-32*gi -: 8];
      assign a2 = sr[111-32*gi -: 8];
      assign a3 = sr[103-32*gi -: 8];
      assign mc[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  assign round_out = mc ^ rk_data;
  assign final_out = sr ^ rk_data;

  // Round-key index: counter in middle rounds, NR in the final round, 0 otherwise.
  always_comb begin
    rk_idx = '0;
    case (fsm_q)
      S_ROUND: rk_idx = cnt_q;
      S_FINAL: rk_idx = NR_IDX;
      default: rk_idx = '0;
    endcase
  end

  // Next-state and next-register computation for the round sequencer.
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d  = in_data ^ rk_data;
          cnt_d = KIDX_W'(1);
          fsm_d = (NR == 1) ? S_FINAL : S_ROUND;
        end
      end
      S_ROUND: begin
        st_d  = round_out;
        cnt_d = cnt_q + KIDX_W'(1);
        if (cnt_q == LAST_ROUND) begin
          fsm_d = S_FINAL;
        end
      end
      S_FINAL: begin
        out_data_d  = final_out;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        fsm_d       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
    in_ready_d = (fsm_d == S_IDLE);
    busy_d     = (fsm_d == S_ROUND) || (fsm_d == S_FINAL);
  end

  // State, data and registered handshake outputs; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef AES_ENGINE_BLKCNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  // Count ciphertext handshakes, wrapping naturally at 2^32.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_valid_q && out_ready) begin
      blk_cnt_d = blk_cnt_q + 32'd1;
    end
  end

  // Block counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed testbench for aes_round_engine: an AES-128 instance and an
// AES-256 instance share clock and reset; each gets its round keys from a
// table the bench expands from the FIPS-197 example keys.
module tb_aes_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_data, a_rk_data, a_out_data;
  logic [3:0]   a_rk_idx;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_in_data, b_rk_data, b_out_data;
  logic [3:0]   b_rk_idx;
`ifdef AES_ENGINE_BLKCNT_EN
  logic [31:0]  a_blk_cnt, b_blk_cnt;
`endif

  logic [127:0] key128 [0:15];
  logic [127:0] key256 [0:15];
  logic [31:0]  kw [0:63];

  assign a_rk_data = key128[a_rk_idx];
  assign b_rk_data = key256[b_rk_idx];

  aes_round_engine #(.NR(10), .KIDX_W(4)) dut128 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .rk_idx(a_rk_idx), .rk_data(a_rk_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy)
`ifdef AES_ENGINE_BLKCNT_EN
    , .blk_cnt(a_blk_cnt)
`endif
  );

  aes_round_engine #(.NR(14), .KIDX_W(4)) dut256 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .rk_idx(b_rk_idx), .rk_data(b_rk_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
`ifdef AES_ENGINE_BLKCNT_EN
    , .blk_cnt(b_blk_cnt)
`endif
  );

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int checks = 0;
  int errors = 0;

  // ---- key expansion (S-box derived from the GF(2^8) inverse) ----
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h01;
    for (int i = 0; i < 254; i++) y = gmul(y, x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = kw[i-1];
      if (i % nk == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subword(temp);
      end
      kw[i] = kw[i-nk] ^ temp;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    checks++; if (a_rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got %0d exp 0", a_rk_idx); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready256 got %b exp 1", b_in_ready); end
`ifdef AES_ENGINE_BLKCNT_EN
    checks++; if (a_blk_cnt !== 32'd0) begin errors++; $display("FAIL reset_blk_cnt got %0d exp 0", a_blk_cnt); end
`endif
    rst = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_aes128();
    a_in_data = PT; a_in_valid = 1'b1; a_out_ready = 1'b0;
    checks++; if (a_rk_idx !== 4'd0) begin errors++; $display("FAIL a128_rk_idx_idle got %0d exp 0", a_rk_idx); end
    tick();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++; if (a_rk_idx !== 4'(k)) begin errors++; $display("FAIL a128_rk_idx got %0d exp %0d", a_rk_idx, k); end
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL a128_early_valid before edge %0d got %b exp 0", k, a_out_valid); end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL a128_busy before edge %0d got %b exp 1", k, a_busy); end
      tick();
    end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL a128_valid got %b exp 1", a_out_valid); end
    checks++; if (a_out_data !== CT128) begin errors++; $display("FAIL a128_data got %h exp %h", a_out_data, CT128); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL a128_done_in_ready got %b exp 0", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL a128_done_busy got %b exp 0", a_busy); end
    checks++; if (a_rk_idx !== 4'd0) begin errors++; $display("FAIL a128_done_rk_idx got %0d exp 0", a_rk_idx); end
    $display("aes128 block out %h", a_out_data);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL a128_release_valid got %b exp 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL a128_release_in_ready got %b exp 1", a_in_ready); end
  endtask

  task automatic test_aes256();
    int n;
    b_in_data = PT; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    n = 1;
    tick();
    while (b_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 14) begin errors++; $display("FAIL a256_latency got %0d exp 14", n); end
    checks++; if (b_out_data !== CT256) begin errors++; $display("FAIL a256_data got %h exp %h", b_out_data, CT256); end
    $display("aes256 block out %h after %0d edges", b_out_data, n);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL a256_release_valid got %b exp 0", b_out_valid); end
  endtask

  task automatic test_backpressure();
    int n;
    a_in_data = PT; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    n = 1;
    tick();
    while (a_out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL bp_latency got %0d exp 10", n); end
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i % 2 == 0);
      a_in_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      tick();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", i, a_out_valid); end
      checks++; if (a_out_data !== CT128) begin errors++; $display("FAIL bp_hold_data cycle %0d got %h exp %h", i, a_out_data, CT128); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b exp 0", i, a_in_ready); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_hold_busy cycle %0d got %b exp 0", i, a_busy); end
    end
    a_in_valid = 1'b1; a_in_data = PT; a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept busy %b in_ready %b exp 1 0", a_busy, a_in_ready); end
    n = 1;
    tick();
    while (a_out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL bp_next_latency got %0d exp 10", n); end
    checks++; if (a_out_data !== CT128) begin errors++; $display("FAIL bp_next_data got %h exp %h", a_out_data, CT128); end
    $display("backpressure block out %h", a_out_data);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    a_in_data = PT; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (a_rk_idx !== 4'd4) begin errors++; $display("FAIL rm_round got %0d exp 4", a_rk_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL rm_out_data got %h exp 0", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", a_busy); end
    checks++; if (b_out_data !== 128'h0) begin errors++; $display("FAIL rm_out_data256 got %h exp 0", b_out_data); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_spurious_output got %b exp 0", seen); end
    a_in_data = PT; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 1;
    tick();
    while (a_out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL rm_next_latency got %0d exp 10", n); end
    checks++; if (a_out_data !== CT128) begin errors++; $display("FAIL rm_next_data got %h exp %h", a_out_data, CT128); end
    $display("post-reset block out %h", a_out_data);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int got;
    int t [0:2];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_in_data = PT; a_in_valid = 1'b1; a_out_ready = 1'b1;
    cyc = 0; got = 0;
    while (got < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (a_out_valid === 1'b1) begin
        checks++; if (a_out_data !== CT128) begin errors++; $display("FAIL b2b_data block %0d got %h exp %h", got, a_out_data, CT128); end
        $display("back-to-back block %0d out %h at cycle %0d", got, a_out_data, cyc);
        t[got] = cyc;
        got++;
      end
    end
    a_in_valid = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got); end
    if (got == 3) begin
      checks++; if (t[1] - t[0] != 12) begin errors++; $display("FAIL b2b_spacing01 got %0d exp 12", t[1] - t[0]); end
      checks++; if (t[2] - t[1] != 12) begin errors++; $display("FAIL b2b_spacing12 got %0d exp 12", t[2] - t[1]); end
    end
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_in_ready got %b exp 1", a_in_ready); end
`ifdef AES_ENGINE_BLKCNT_EN
    checks++; if (a_blk_cnt !== 32'd3) begin errors++; $display("FAIL b2b_blk_cnt got %0d exp 3", a_blk_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      key128[r] = '0;
      key256[r] = '0;
    end
    expand_key(K128, 4, 10);
    for (int r = 0; r <= 10; r++) key128[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
    expand_key(K256, 8, 14);
    for (int r = 0; r <= 14; r++) key256[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};

    test_reset();
    test_aes128();
    test_aes256();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
